// File: rtl/uni2bin_acc.sv
// uni2bin_acc: counts the 1s of a unary bitstream over a 2^DATAWD-cycle window and returns the saturated binary count.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   iStart        begin one conversion (only sampled in IDLE or at a HOLD handshake)
//   iBit          unary bitstream from the upstream multiplier
//   oLoad         one-cycle strobe to the upstream operand buffers
//   oBusy         high whenever not IDLE
//   oValid/iReady result handshake
//   oData         saturated ones count, held until the next result
module uni2bin_acc #(
  parameter int DATAWD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iStart,
  input  logic              iBit,
  output logic              oLoad,
  output logic              oBusy,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATAWD-1:0] oData
);
  typedef enum logic [1:0] {IDLE, LOAD, ACCUM, HOLD} state_t;
  state_t state, state_nxt;
  logic [DATAWD-1:0] win;
  logic [DATAWD:0] ones, ones_nxt;
  logic last;
  always_comb begin
    ones_nxt = ones + (DATAWD+1)'(iBit);
    last = (state == ACCUM) && (win == '1);
    state_nxt = state == IDLE  ? (iStart ? LOAD : IDLE) :
                state == LOAD  ? ACCUM :
                state == ACCUM ? (last ? HOLD : ACCUM) :
                iReady         ? (iStart ? LOAD : IDLE) : HOLD;
    oLoad = state == LOAD;
    oBusy = state != IDLE;
    oValid = state == HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      win <= '0;
      ones <= '0;
      oData <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt == LOAD) ones <= '0;
      else if (state == ACCUM) ones <= ones_nxt;
      if (state == LOAD) win <= '0;
      else if (state == ACCUM) win <= win + 1'b1;
      // the final sample is folded in directly so the result is ready on entry to HOLD
      if (last) oData <= ones_nxt[DATAWD] ? '1 : ones_nxt[DATAWD-1:0];
    end
  end
endmodule
